// File: rtl/mips_pkg.sv
// Shared MIPS boot-path types and constants: loader FSM states and word geometry.
package mips_pkg;

  localparam int unsigned MIPS_WORD_W           = 32;
  localparam int unsigned LOADER_BYTES_PER_WORD = 4;
  localparam int unsigned LOADER_BYTE_W         = 8;
  localparam int unsigned LOADER_CNT_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, IMEM write and core-control signals between a boot source and imem_loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);

  logic              i_start_w;
  logic              i_byte_valid_w;
  logic [7:0]        i_byte_w;
  logic              o_byte_ready_w;
  logic              o_imem_we_w;
  logic [ADDR_W-1:0] o_imem_addr_w;
  logic [31:0]       o_imem_wd_w;
  logic              o_cpu_rst_w;
  logic              o_busy_w;
  logic              o_done_w;
  logic              o_err_w;

  modport master (
    output i_start_w, i_byte_valid_w, i_byte_w,
    input  o_byte_ready_w, o_imem_we_w, o_imem_addr_w, o_imem_wd_w,
           o_cpu_rst_w, o_busy_w, o_done_w, o_err_w
  );

  modport slave (
    input  i_start_w, i_byte_valid_w, i_byte_w,
    output o_byte_ready_w, o_imem_we_w, o_imem_addr_w, o_imem_wd_w,
           o_cpu_rst_w, o_busy_w, o_done_w, o_err_w
  );

endinterface

// File: rtl/word_assembler.sv
// Packs bytes MSB-first into a 32-bit word; full_c flags the shift that completes a word.
module word_assembler
  import mips_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic [LOADER_BYTE_W-1:0] byte_in,
  output logic [MIPS_WORD_W-1:0]   word_c,
  output logic                     full_c
);

  logic [MIPS_WORD_W-1:0]  word;
  logic [LOADER_CNT_W-1:0] cnt;

  // word_c already contains the byte being shifted this cycle
  assign word_c = {word[MIPS_WORD_W-LOADER_BYTE_W-1:0], byte_in};
  assign full_c = shift_en && (cnt == LOADER_CNT_W'(LOADER_BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= word_c;
      cnt  <= cnt + LOADER_CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams length + program words into IMEM and holds the core in reset until done.
// Optional trailing XOR checksum when LOADER_CHECKSUM_EN is defined.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input logic            i_clk_w,
  input logic            i_rst_w,
  imem_loader_if.slave   bus
);

  loader_state_e          state;
  logic [ADDR_W-1:0]      len;
  logic [ADDR_W-1:0]      word_idx;
  logic                   xfer_c;
  logic                   asm_shift_c;
  logic                   asm_clr_c;
  logic                   asm_full_c;
  logic [MIPS_WORD_W-1:0] asm_word_c;
`ifdef LOADER_CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] chk_acc;
`endif

  assign bus.o_byte_ready_w = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign xfer_c             = bus.i_byte_valid_w && bus.o_byte_ready_w;
  assign asm_shift_c        = xfer_c && (state == ST_DATA);
  assign asm_clr_c          = (xfer_c && (state == ST_LEN)) || (state == ST_WRITE);

  word_assembler u_asm (
    .clk      (i_clk_w),
    .rst      (i_rst_w),
    .clr      (asm_clr_c),
    .shift_en (asm_shift_c),
    .byte_in  (bus.i_byte_w),
    .word_c   (asm_word_c),
    .full_c   (asm_full_c)
  );

  // Strobe, address and data are launched on the edge that accepts a word's last byte
  always_ff @(posedge i_clk_w or posedge i_rst_w) begin
    if (i_rst_w) begin
      state             <= ST_IDLE;
      len               <= '0;
      word_idx          <= '0;
      bus.o_imem_we_w   <= 1'b0;
      bus.o_imem_addr_w <= '0;
      bus.o_imem_wd_w   <= '0;
      bus.o_cpu_rst_w   <= 1'b1;
      bus.o_busy_w      <= 1'b0;
      bus.o_done_w      <= 1'b0;
      bus.o_err_w       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc           <= '0;
`endif
    end else begin
      bus.o_imem_we_w <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.i_start_w) begin
            state           <= ST_LEN;
            bus.o_busy_w    <= 1'b1;
            bus.o_done_w    <= 1'b0;
            bus.o_err_w     <= 1'b0;
            bus.o_cpu_rst_w <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_acc         <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (xfer_c) begin
            len      <= bus.i_byte_w[ADDR_W-1:0];
            word_idx <= '0;
            state    <= ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ bus.i_byte_w;
`endif
          end
        end
        ST_DATA: begin
          if (xfer_c) begin
`ifdef LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ bus.i_byte_w;
`endif
            if (asm_full_c) begin
              state             <= ST_WRITE;
              bus.o_imem_we_w   <= 1'b1;
              bus.o_imem_addr_w <= word_idx;
              bus.o_imem_wd_w   <= asm_word_c;
            end
          end
        end
        ST_WRITE: begin
          if (word_idx == len) begin
`ifdef LOADER_CHECKSUM_EN
            state           <= ST_CHK;
`else
            state           <= ST_DONE;
            bus.o_busy_w    <= 1'b0;
            bus.o_done_w    <= 1'b1;
            bus.o_cpu_rst_w <= 1'b0;
`endif
          end else begin
            word_idx <= word_idx + ADDR_W'(1);
            state    <= ST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer_c) begin
            bus.o_busy_w <= 1'b0;
            if (bus.i_byte_w == chk_acc) begin
              state           <= ST_DONE;
              bus.o_done_w    <= 1'b1;
              bus.o_cpu_rst_w <= 1'b0;
            end else begin
              state           <= ST_ERR;
              bus.o_err_w     <= 1'b1;
              bus.o_cpu_rst_w <= 1'b1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner sequences, random loads.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int unsigned ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk_w (clk),
    .i_rst_w (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wq_a[$];
  logic [31:0]       wq_d[$];

  // Record every IMEM write strobe seen mid-cycle
  always @(negedge clk) begin
    if (bus.o_imem_we_w) begin
      wq_a.push_back(bus.o_imem_addr_w);
      wq_d.push_back(bus.o_imem_wd_w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start_w = 1'b1;
    tick();
    bus.i_start_w = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.i_byte_valid_w = 1'b0;
      tick();
    end
    bus.i_byte_valid_w = 1'b1;
    bus.i_byte_w       = b;
    n = 0;
    while (!bus.o_byte_ready_w && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready never rose for byte %h", b);
    end
    tick();
    bus.i_byte_valid_w = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(bus.o_done_w || bus.o_err_w) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: neither done nor err after 20 cycles");
    end
  endtask

  // Full load: start, LEN byte, data bytes, optional checksum byte, then wait for completion
  task automatic run_load(input logic [7:0] len_b, input logic [7:0] data[$],
                          input int gap_lo, input int gap_hi, input bit bad_chk);
    logic [7:0] x;
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    chk("start_busy", 32'(bus.o_busy_w), 32'd1);
    send_byte(len_b, $urandom_range(gap_hi, gap_lo));
    x = len_b;
    foreach (data[i]) begin
      send_byte(data[i], $urandom_range(gap_hi, gap_lo));
      x = x ^ data[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, $urandom_range(gap_hi, gap_lo));
`else
    x = x ^ 8'(bad_chk);
`endif
    wait_end();
  endtask

  task automatic check_end(input bit ok);
    chk("end_done",    32'(bus.o_done_w),       32'(ok));
    chk("end_err",     32'(bus.o_err_w),        32'(!ok));
    chk("end_cpu_rst", 32'(bus.o_cpu_rst_w),    32'(!ok));
    chk("end_busy",    32'(bus.o_busy_w),       32'd0);
    chk("end_ready",   32'(bus.o_byte_ready_w), 32'd0);
  endtask

  task automatic check_writes(input logic [31:0] exp_w[$]);
    chk("wr_count", 32'(wq_d.size()), 32'(exp_w.size()));
    foreach (exp_w[k]) begin
      chk($sformatf("wr_addr%0d", k), (k < wq_a.size()) ? 32'(wq_a[k]) : 32'hxxxx_xxxx, 32'(k));
      chk($sformatf("wr_data%0d", k), (k < wq_d.size()) ? wq_d[k] : 32'hxxxx_xxxx, exp_w[k]);
    end
  endtask

  typedef struct {
    logic [7:0]   len_b;
    logic [127:0] stream;
    int           n_bytes;
    int           gap_lo;
    int           gap_hi;
    int           exp_n;
    logic [31:0]  exp_w[4];
  } vec_t;

  vec_t       vec[4];
  logic [7:0] dq[$];
  logic [31:0] eq[$];

  initial begin
    bus.i_start_w      = 1'b0;
    bus.i_byte_valid_w = 1'b0;
    bus.i_byte_w       = 8'h00;

    vec[0] = '{8'h01, 128'h20080005_8C090000_00000000_00000000, 8, 0, 0, 2,
               '{32'h20080005, 32'h8C090000, 32'h0, 32'h0}};
    vec[1] = '{8'h01, 128'h20080005_8C090000_00000000_00000000, 8, 1, 3, 2,
               '{32'h20080005, 32'h8C090000, 32'h0, 32'h0}};
    vec[2] = '{8'h00, 128'hDEADBEEF_00000000_00000000_00000000, 4, 0, 1, 1,
               '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}};
    vec[3] = '{8'h43, 128'h00010203_04050607_08090A0B_0C0D0E0F, 16, 0, 1, 4,
               '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F}};

    // Reset values
    rst = 1'b1;
    #23;
    chk("rst_cpu_rst", 32'(bus.o_cpu_rst_w),    32'd1);
    chk("rst_busy",    32'(bus.o_busy_w),       32'd0);
    chk("rst_done",    32'(bus.o_done_w),       32'd0);
    chk("rst_err",     32'(bus.o_err_w),        32'd0);
    chk("rst_we",      32'(bus.o_imem_we_w),    32'd0);
    chk("rst_ready",   32'(bus.o_byte_ready_w), 32'd0);
    chk("rst_addr",    32'(bus.o_imem_addr_w),  32'd0);
    chk("rst_wd",      bus.o_imem_wd_w,         32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.o_byte_ready_w), 32'd0);

    // Table-driven loads
    foreach (vec[v]) begin
      dq.delete();
      eq.delete();
      for (int i = 0; i < vec[v].n_bytes; i++) dq.push_back(vec[v].stream[127 - 8*i -: 8]);
      for (int k = 0; k < vec[v].exp_n; k++) eq.push_back(vec[v].exp_w[k]);
      run_load(vec[v].len_b, dq, vec[v].gap_lo, vec[v].gap_hi, 1'b0);
      check_end(1'b1);
      check_writes(eq);
    end

    // Strobe latency: one cycle after the 4th byte is accepted
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    chk("lat_no_we_early", 32'(bus.o_imem_we_w), 32'd0);
    send_byte(8'hDD, 0);
    chk("lat_we",    32'(bus.o_imem_we_w),    32'd1);
    chk("lat_wd",    bus.o_imem_wd_w,         32'hAABBCCDD);
    chk("lat_addr",  32'(bus.o_imem_addr_w),  32'd0);
    chk("lat_ready", 32'(bus.o_byte_ready_w), 32'd0);
    tick();
    chk("lat_we_off", 32'(bus.o_imem_we_w), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("chk_ready", 32'(bus.o_byte_ready_w), 32'd1);
    send_byte(8'h00, 0);
    check_end(1'b1);
    // Same stream, wrong checksum
    dq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(8'h00, dq, 0, 0, 1'b1);
    check_end(1'b0);
    check_writes('{32'hAABBCCDD});
`else
    check_end(1'b1);
`endif

    // Asynchronous reset after two data bytes, then a clean reload
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cpu_rst", 32'(bus.o_cpu_rst_w),    32'd1);
    chk("mid_rst_busy",    32'(bus.o_busy_w),       32'd0);
    chk("mid_rst_ready",   32'(bus.o_byte_ready_w), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_rst_no_strobe", 32'(wq_d.size()), 32'd0);
    chk("mid_rst_done",      32'(bus.o_done_w), 32'd0);
    dq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    run_load(8'h01, dq, 0, 0, 1'b0);
    check_end(1'b1);
    check_writes('{32'h20080005, 32'h8C090000});

    // Start pulsed during DATA is ignored
    wq_a.delete();
    wq_d.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    chk("data_start_busy", 32'(bus.o_busy_w), 32'd1);
    dq = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    foreach (dq[i]) send_byte(dq[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 0);
`endif
    wait_end();
    check_end(1'b1);
    check_writes('{32'h11223344, 32'h55667788});

    // Start in DONE re-asserts core reset on the next cycle
    pulse_start();
    chk("restart_cpu_rst", 32'(bus.o_cpu_rst_w),    32'd1);
    chk("restart_busy",    32'(bus.o_busy_w),       32'd1);
    chk("restart_done",    32'(bus.o_done_w),       32'd0);
    chk("restart_ready",   32'(bus.o_byte_ready_w), 32'd1);
    wq_a.delete();
    wq_d.delete();
    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_byte(8'h00, 0);
    foreach (dq[i]) send_byte(dq[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 0);
`endif
    wait_end();
    check_end(1'b1);
    check_writes('{32'h01020304});

    // Random loads against the stream-level reference model
    for (int t = 0; t < 20; t++) begin
      logic [7:0] len_b;
      int         n_words;
      bit         bad;
      len_b   = 8'(($urandom_range(3, 0) << ADDR_W) | $urandom_range(5, 0));
      n_words = int'(len_b % (1 << ADDR_W)) + 1;
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(3, 0) == 0);
`else
      bad = 1'b0;
`endif
      dq.delete();
      eq.delete();
      for (int i = 0; i < 4 * n_words; i++) dq.push_back(8'($urandom));
      for (int k = 0; k < n_words; k++)
        eq.push_back({dq[4*k], dq[4*k+1], dq[4*k+2], dq[4*k+3]});
      run_load(len_b, dq, 0, 2, bad);
      check_end(!bad);
      check_writes(eq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
